centroid_scheduler: RTL

CENTROID_SCHEDULER -- requirements
Module: centroid_scheduler

---
 rtl/juggler_pkg.sv | 39 +++
 rtl/centroid_scheduler_seed_table.sv | 18 +
 rtl/centroid_scheduler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/juggler_pkg.sv
// juggler_pkg -- definitions shared across the juggler vision pipeline.
//   Frame geometry, the centroid coordinate types, the centroid scheduler
//   state encoding and the default k-means seed constants.
package juggler_pkg;

  localparam int FRAME_WIDTH  = 320;
  localparam int FRAME_HEIGHT = 180;
  localparam int MAX_BALLS    = 7;

  localparam int CX_W = 9;   // covers 0..FRAME_WIDTH-1
  localparam int CY_W = 8;   // covers 0..FRAME_HEIGHT-1

  typedef logic [CX_W-1:0] cx_t;
  typedef logic [CY_W-1:0] cy_t;
  typedef logic [2:0]      ball_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    STORE,
    SOLVE,
    PUBLISH
  } sched_state_t;

  // Default seeds spread evenly across the frame on one horizontal line.
  localparam cx_t SEED_X_STEP = 9'd40;
  localparam cy_t SEED_Y      = 8'd90;

  function automatic cx_t default_seed_x(input ball_idx_t idx);
    cx_t slot;
    slot = {6'd0, idx} + 9'd1;
    return slot * SEED_X_STEP;
  endfunction

  function automatic cy_t default_seed_y(input ball_idx_t idx);
    return (idx == idx) ? SEED_Y : SEED_Y;
  endfunction

endpackage

// File: rtl/centroid_scheduler_seed_table.sv
// seed_table -- combinational default-seed generator.
//   idx    : centroid slot index
//   seed_x : default x seed for the slot, 40*(idx+1)
//   seed_y : default y seed for the slot, constant 90
module seed_table
  import juggler_pkg::*;
(
  input  ball_idx_t idx,
  output cx_t       seed_x,
  output cy_t       seed_y
);

  always_comb begin
    seed_x = default_seed_x(idx);
    seed_y = default_seed_y(idx);
  end

endmodule

// File: rtl/centroid_scheduler.sv
// centroid_scheduler -- sequences the k-means engine once per camera frame.
//   Arms k-means with seeds at frame start (km_rst_out), flags the end of
//   pixel storage (km_new_frame_out), waits for the result with a timeout,
//   publishes centroids (valid_out) and feeds the result back as the next
//   frame's seeds.
// Ports:
//   clk_in, rst_in (async, active-high)
//   frame_start_in, frame_end_in, num_balls_in, reseed_in : frame control
//   km_valid_in, km_x_in, km_y_in                          : k-means result
//   km_rst_out, km_new_frame_out, seed_x_out, seed_y_out,
//   km_num_balls_out                                       : k-means control
//   centroids_x_out, centroids_y_out, valid_out            : published result
//   busy_out, timeout_out                                  : status
// Build option: define STATS_EN to add frames_done_out, frames_dropped_out
//   and solve_cycles_out statistics ports.
module centroid_scheduler
  import juggler_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000,
  parameter int unsigned MAX_BALLS      = juggler_pkg::MAX_BALLS
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  frame_start_in,
  input  logic                  frame_end_in,
  input  logic [2:0]            num_balls_in,
  input  logic                  reseed_in,
  input  logic                  km_valid_in,
  input  cx_t  [MAX_BALLS-1:0]  km_x_in,
  input  cy_t  [MAX_BALLS-1:0]  km_y_in,
  output logic                  km_rst_out,
  output logic                  km_new_frame_out,
  output cx_t  [MAX_BALLS-1:0]  seed_x_out,
  output cy_t  [MAX_BALLS-1:0]  seed_y_out,
  output logic [2:0]            km_num_balls_out,
  output cx_t  [MAX_BALLS-1:0]  centroids_x_out,
  output cy_t  [MAX_BALLS-1:0]  centroids_y_out,
  output logic                  valid_out,
  output logic                  busy_out,
  output logic                  timeout_out
`ifdef STATS_EN
  ,
  output logic [15:0]           frames_done_out,
  output logic [15:0]           frames_dropped_out,
  output logic [23:0]           solve_cycles_out
`endif
);

  sched_state_t state_q, state_d;

  logic        arm_go;
  logic        store_done;
  logic        km_take;
  logic        timeout_hit;
  logic [23:0] solve_cnt_q;
  logic        reseed_pend_q;
  logic [2:0]  nb_clamped;

  cx_t [MAX_BALLS-1:0] def_x;
  cy_t [MAX_BALLS-1:0] def_y;

  for (genvar g = 0; g < MAX_BALLS; g++) begin : g_seed
    seed_table u_seed_table (
      .idx    (ball_idx_t'(g)),
      .seed_x (def_x[g]),
      .seed_y (def_y[g])
    );
  end

  always_comb begin
    nb_clamped = num_balls_in;
    if (num_balls_in == 3'd0)
      nb_clamped = 3'd1;
    else if (32'(num_balls_in) > MAX_BALLS)
      nb_clamped = 3'(MAX_BALLS);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    arm_go      = 1'b0;
    store_done  = 1'b0;
    km_take     = 1'b0;
    timeout_hit = 1'b0;
    km_rst_out  = 1'b0;
    valid_out   = 1'b0;
    busy_out    = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy_out = 1'b0;
        // frame_start wins over a coincident frame_end: STORE only looks at
        // frame_end from the following frame onward.
        if (frame_start_in) begin
          arm_go  = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        km_rst_out = 1'b1;
        state_d    = STORE;
      end
      STORE: begin
        if (frame_end_in) begin
          store_done = 1'b1;
          state_d    = SOLVE;
        end
      end
      SOLVE: begin
        if (km_valid_in) begin
          km_take = 1'b1;
          state_d = PUBLISH;
        end else if (solve_cnt_q == TIMEOUT_CYCLES - 24'd1) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      PUBLISH: begin
        valid_out = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Seed registers only change on the IDLE->ARM edge or when SOLVE is left,
  // so k-means sees stable seeds from ARM through SOLVE. A reseed request is
  // parked until the next ARM so it cannot disturb a frame in flight.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      km_new_frame_out <= 1'b0;
      km_num_balls_out <= 3'd1;
      solve_cnt_q      <= '0;
      reseed_pend_q    <= 1'b0;
      timeout_out      <= 1'b0;
      centroids_x_out  <= '0;
      centroids_y_out  <= '0;
      for (int unsigned i = 0; i < MAX_BALLS; i++) begin
        seed_x_out[i] <= default_seed_x(ball_idx_t'(i));
        seed_y_out[i] <= default_seed_y(ball_idx_t'(i));
      end
    end else begin
      km_new_frame_out <= store_done;

      if (store_done)
        solve_cnt_q <= '0;
      else if (state_q == SOLVE)
        solve_cnt_q <= solve_cnt_q + 24'd1;

      if (arm_go)
        km_num_balls_out <= nb_clamped;

      if (arm_go)
        reseed_pend_q <= 1'b0;
      else if (reseed_in)
        reseed_pend_q <= 1'b1;

      if (timeout_hit)
        timeout_out <= 1'b1;
      else if (km_take)
        timeout_out <= 1'b0;

      for (int unsigned i = 0; i < MAX_BALLS; i++) begin
        if (km_take) begin
          centroids_x_out[i] <= km_x_in[i];
          centroids_y_out[i] <= km_y_in[i];
        end
        if (arm_go) begin
          if (reseed_pend_q || reseed_in || i >= 32'(nb_clamped)) begin
            seed_x_out[i] <= def_x[i];
            seed_y_out[i] <= def_y[i];
          end
        end else if (timeout_hit) begin
          seed_x_out[i] <= def_x[i];
          seed_y_out[i] <= def_y[i];
        end else if (km_take) begin
          if (i < 32'(km_num_balls_out)) begin
            seed_x_out[i] <= km_x_in[i];
            seed_y_out[i] <= km_y_in[i];
          end else begin
            seed_x_out[i] <= def_x[i];
            seed_y_out[i] <= def_y[i];
          end
        end
      end
    end
  end

`ifdef STATS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frames_done_out    <= '0;
      frames_dropped_out <= '0;
      solve_cycles_out   <= '0;
    end else begin
      if (km_take) begin
        frames_done_out  <= frames_done_out + 16'd1;
        solve_cycles_out <= solve_cnt_q + 24'd1;
      end
      if (frame_start_in && state_q != IDLE)
        frames_dropped_out <= frames_dropped_out + 16'd1;
    end
  end
`endif

endmodule
